// File: rtl/fa4b_seq_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package fa4b_seq_adder_ctrl_pkg;

    localparam int unsigned SliceW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Slice index width; a single-slice build still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/fa4b_seq_adder_ctrl_if.sv
// Start/done request bus between a requester and the serial adder controller.
interface fa4b_seq_adder_ctrl_if #(
    parameter int unsigned NIBBLES = 4
);
    import fa4b_seq_adder_ctrl_pkg::*;

    localparam int unsigned W = SliceW * NIBBLES;

    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    modport master (
        output start, a_in, b_in, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a_in, b_in, c_in,
        output busy, done, sum, c_out
    );

endinterface

// File: rtl/fa4b_seq_adder_ctrl_fa4b.sv
// Combinational 4-bit ripple-carry adder shared by every slice.
module fa4b_seq_adder_ctrl_fa4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    always_comb begin : p_ripple
        logic cy;
        cy = ci;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        co = cy;
    end

endmodule

// File: rtl/fa4b_seq_adder_ctrl.sv
// Wide adder built by stepping one 4-bit adder over NIBBLES slices, LSB first.
module fa4b_seq_adder_ctrl
    import fa4b_seq_adder_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input logic                   clk,
    input logic                   rst,
    fa4b_seq_adder_ctrl_if.slave  bus
);

    localparam int unsigned W    = SliceW * NIBBLES;
    localparam int unsigned IdxW = idx_width(NIBBLES);
    localparam int unsigned LsbW = $clog2(W);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    work_q, work_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q;
    logic            c_out_q, busy_q, done_q;

    logic [LsbW-1:0]   slice_lsb;
    logic [SliceW-1:0] fa_a, fa_b, fa_s;
    logic              fa_co;

    assign slice_lsb = LsbW'(idx_q) << $clog2(SliceW);
    assign fa_a      = a_q[slice_lsb +: SliceW];
    assign fa_b      = b_q[slice_lsb +: SliceW];

    fa4b_seq_adder_ctrl_fa4b u_fa4b (
        .a  (fa_a),
        .b  (fa_b),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    carry_d = bus.c_in;
                    idx_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                work_d[slice_lsb +: SliceW] = fa_s;
                carry_d = fa_co;
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
            // Result is published only on entry to DONE so partial slices stay hidden.
            if (state_d == StDone) begin
                sum_q   <= work_d;
                c_out_q <= carry_d;
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_fa4b_seq_adder_ctrl.sv
// Scoreboard bench for the serial adder controller (NIBBLES=4 and NIBBLES=1).
module tb_fa4b_seq_adder_ctrl;

    localparam int N = 4;

    typedef struct {
        logic [15:0] sum;
        logic        c;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    logic [15:0] held_sum = '0;
    logic        held_c = 1'b0;
    int          busy_run = 0;

    fa4b_seq_adder_ctrl_if #(.NIBBLES(4)) bus4 ();
    fa4b_seq_adder_ctrl_if #(.NIBBLES(1)) bus1 ();

    fa4b_seq_adder_ctrl #(.NIBBLES(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    fa4b_seq_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done and polices hold/exclusion.
    always @(negedge clk) begin
        if (rst) begin
            held_sum = '0;
            held_c   = 1'b0;
            busy_run = 0;
        end else begin
            chk("busy_done_excl", 32'(bus4.busy & bus4.done), 32'd0);
            if (bus4.busy) busy_run++;
            if (bus4.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", 32'(bus4.sum), 32'(e.sum));
                    chk("c_out", 32'(bus4.c_out), 32'(e.c));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_len", 32'(busy_run), 32'(N));
                    held_sum = e.sum;
                    held_c   = e.c;
                end
                busy_run = 0;
            end else begin
                chk("sum_hold", 32'(bus4.sum), 32'(held_sum));
                chk("c_out_hold", 32'(bus4.c_out), 32'(held_c));
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] es, input logic ec, input bit accepted);
        exp_t e;
        bus4.start = 1'b1;
        bus4.a_in  = a;
        bus4.b_in  = b;
        bus4.c_in  = c;
        if (accepted) begin
            e.sum = es;
            e.c   = ec;
            e.cyc = cyc + 1 + N;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus4.a_in  = 16'hDEAD;
        bus4.b_in  = 16'hBEEF;
        bus4.c_in  = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] rs;

        bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0; bus4.c_in = 1'b0;
        bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_done", 32'(bus4.done), 32'd0);
        chk("rst_sum", 32'(bus4.sum), 32'd0);
        chk("rst_c_out", 32'(bus4.c_out), 32'd0);
        chk("rst1_sum", 32'(bus1.sum), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        drain();
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        drain();
        issue(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b1);
        drain();

        // Back-to-back: second start lands in the DONE cycle of the first.
        issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        repeat (N) @(posedge clk);
        #1;
        chk("b2b_in_done", 32'(bus4.done), 32'd1);
        issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b1);
        drain();

        // Start during RUN must be ignored.
        issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        issue(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);
        drain();

        // Reset in RUN cycle 3 aborts the operation with no done.
        issue(16'h5555, 16'h5555, 1'b0, 16'hAAAA, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        void'(q.pop_back());
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(bus4.busy), 32'd0);
        chk("abort_done", 32'(bus4.done), 32'd0);
        chk("abort_sum", 32'(bus4.sum), 32'd0);
        chk("abort_c_out", 32'(bus4.c_out), 32'd0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        issue(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            issue(ra, rb, rc, rs[15:0], rs[16], 1'b1);
            repeat (N) @(posedge clk);
            #1;
        end
        drain();

        // Single-slice build: one RUN cycle, done at T+2, back-to-back in DONE.
        bus1.start = 1'b1; bus1.a_in = 4'hF; bus1.b_in = 4'h1; bus1.c_in = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        chk("n1_busy", 32'(bus1.busy), 32'd1);
        chk("n1_done_early", 32'(bus1.done), 32'd0);
        @(posedge clk);
        #1;
        chk("n1_done", 32'(bus1.done), 32'd1);
        chk("n1_busy_in_done", 32'(bus1.busy), 32'd0);
        chk("n1_sum", 32'(bus1.sum), 32'h1);
        chk("n1_c_out", 32'(bus1.c_out), 32'd1);
        bus1.start = 1'b1; bus1.a_in = 4'h7; bus1.b_in = 4'h8; bus1.c_in = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        chk("n1_b2b_busy", 32'(bus1.busy), 32'd1);
        chk("n1_hold_sum", 32'(bus1.sum), 32'h1);
        @(posedge clk);
        #1;
        chk("n1_b2b_done", 32'(bus1.done), 32'd1);
        chk("n1_b2b_sum", 32'(bus1.sum), 32'h0);
        chk("n1_b2b_c_out", 32'(bus1.c_out), 32'd1);
        @(posedge clk);
        #1;
        chk("n1_idle_done", 32'(bus1.done), 32'd0);
        chk("n1_idle_busy", 32'(bus1.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
